// File: rtl/gru_gate_mac_pkg.sv
// -----------------------------------------------------------------------------
// gru_gate_mac_pkg
// Shared constants and types for the GRU gate MAC stage and its activation
// helper.
//   - Q2.14 fixed-point format: width, fractional bits, 1.0 / 0.5 / +-limits
//   - Default NIN / accumulator width
//   - Activation selector values (hard sigmoid for zt, hard tanh for htb)
//   - Gate FSM state encoding
//   - cnt_width(): counter width that stays >= 1 bit even when NIN == 1
// -----------------------------------------------------------------------------
package gru_gate_mac_pkg;

    localparam int GRU_DATABIT = 16;
    localparam int GRU_FRAC    = 14;
    localparam int GRU_NIN     = 8;
    localparam int GRU_ACCBIT  = 40;

    // Q2.14 constants (1.0 = 0x4000)
    localparam logic signed [15:0] ONE_Q     = 16'sh4000;
    localparam logic signed [15:0] HALF_Q    = 16'sh2000;
    localparam logic signed [15:0] NEG_ONE_Q = 16'shC000;
    localparam logic signed [15:0] Q_MAX     = 16'sh7FFF;
    localparam logic signed [15:0] Q_MIN     = 16'sh8000;

    // Activation selector values for the ACT_TANH parameter
    localparam int ACT_SEL_SIGMOID = 0;
    localparam int ACT_SEL_TANH    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ACT  = 2'd2,
        ST_DONE = 2'd3
    } gate_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gru_pwl_act.sv
// -----------------------------------------------------------------------------
// gru_pwl_act
// Purely combinational piecewise-linear activation on a wide Q4.28-style
// accumulator. Rounds half up back to Q2.14 scale, then applies either
//   hard sigmoid : y = clamp((r >>> 2) + 0.5, 0, 1.0)
//   hard tanh    : y = clamp(r, -1.0, 1.0)
// The intermediate stays at ACCBIT width so the clamp sees the true value
// instead of a truncated, possibly wrapped one.
// Ports:
//   acc_i  in   ACCBIT   signed accumulator (FRAC extra fractional bits)
//   y_o    out  DATABIT  signed Q2.14 activation result
// -----------------------------------------------------------------------------
module gru_pwl_act
    import gru_gate_mac_pkg::*;
#(
    parameter int DATABIT  = GRU_DATABIT,
    parameter int FRAC     = GRU_FRAC,
    parameter int ACCBIT   = GRU_ACCBIT,
    parameter int ACT_TANH = ACT_SEL_SIGMOID
) (
    input  logic signed [ACCBIT-1:0]  acc_i,
    output logic signed [DATABIT-1:0] y_o
);

    localparam logic signed [ACCBIT-1:0] ONE_W     = ACCBIT'(ONE_Q);
    localparam logic signed [ACCBIT-1:0] NEG_ONE_W = ACCBIT'(NEG_ONE_Q);
    localparam logic signed [ACCBIT-1:0] HALF_W    = ACCBIT'(HALF_Q);
    // Half an output LSB, expressed at accumulator scale
    localparam logic signed [ACCBIT-1:0] RND_W     = ACCBIT'(1) <<< (FRAC - 1);
    localparam logic signed [ACCBIT-1:0] LO_W      = (ACT_TANH != 0) ? NEG_ONE_W : '0;

    logic signed [ACCBIT-1:0] rnd;
    logic signed [ACCBIT-1:0] act;
    logic signed [ACCBIT-1:0] clip;

    always_comb begin
        rnd = (acc_i + RND_W) >>> FRAC;
    end

    generate
        if (ACT_TANH != 0) begin : g_tanh
            always_comb act = rnd;
        end else begin : g_sigmoid
            always_comb act = (rnd >>> 2) + HALF_W;
        end
    endgenerate

    always_comb begin
        clip = act;
        if (act > ONE_W) begin
            clip = ONE_W;
        end else if (act < LO_W) begin
            clip = LO_W;
        end
        y_o = DATABIT'(clip);
    end

endmodule

// File: rtl/gru_gate_mac.sv
// -----------------------------------------------------------------------------
// gru_gate_mac
// One GRU gate value (zt via hard sigmoid, or htb via hard tanh). A start
// loads the bias into the accumulator, NIN (data, weight) pairs are
// multiply-accumulated serially with valid/ready flow control, and the
// activation produces one Q2.14 result.
// Flow: IDLE -start-> ACC -NIN-th pair-> ACT (1 cycle) -> DONE (1 cycle) -> IDLE
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        synchronous reset, ACTIVE HIGH despite the name
//   start      in   1        begin a result (only honoured in IDLE)
//   bias       in   DATABIT  Q2.14 bias, sampled with start
//   in_valid   in   1        pair valid
//   in_ready   out  1        pair accepted when in_valid & in_ready
//   in_data    in   DATABIT  Q2.14 element
//   in_weight  in   DATABIT  Q2.14 weight
//   busy       out  1        not IDLE
//   out_valid  out  1        one-cycle result strobe (DONE)
//   out_data   out  DATABIT  Q2.14 result, registered and held between results
// -----------------------------------------------------------------------------
module gru_gate_mac
    import gru_gate_mac_pkg::*;
#(
    parameter int DATABIT  = GRU_DATABIT,
    parameter int FRAC     = GRU_FRAC,
    parameter int NIN      = GRU_NIN,
    parameter int ACCBIT   = GRU_ACCBIT,
    parameter int ACT_TANH = ACT_SEL_SIGMOID
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [DATABIT-1:0] bias,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATABIT-1:0] in_data,
    input  logic signed [DATABIT-1:0] in_weight,
    output logic                      busy,
    output logic                      out_valid,
    output logic signed [DATABIT-1:0] out_data
);

    localparam int              CNTW     = cnt_width(NIN);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NIN - 1);

    gate_state_e               state_q, state_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic signed [ACCBIT-1:0]  acc_q, acc_d;
    logic signed [DATABIT-1:0] out_data_q, out_data_d;

    logic signed [2*DATABIT-1:0] prod;
    logic signed [DATABIT-1:0]   act_y;

    // Full-precision product; sign-extended into the accumulator below.
    assign prod = in_data * in_weight;

    gru_pwl_act #(
        .DATABIT  (DATABIT),
        .FRAC     (FRAC),
        .ACCBIT   (ACCBIT),
        .ACT_TANH (ACT_TANH)
    ) u_act (
        .acc_i (acc_q),
        .y_o   (act_y)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Bias is Q2.14; align it to the Q4.28 product scale.
                    acc_d   = ACCBIT'(bias) <<< FRAC;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = acc_q + ACCBIT'(prod);
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_ACT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ACT: begin
                out_data_d = act_y;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                // A start seen here is intentionally dropped; it is only
                // honoured once back in IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;

endmodule
